// File: rtl/mux5bit_2to1_pkg.sv
// Shared constants for the register-address select path.
// REG_ADDR_W is the register-file address width; the register file and the
// other address muxes import it so they all agree on one number.
package mux5bit_2to1_pkg;

  localparam int REG_ADDR_W = 5;

endpackage : mux5bit_2to1_pkg

// File: rtl/mux5bit_2to1_if.sv
// Signal bundle for the 2-to-1 address/operand select block.
// Protocol: there is no valid/ready handshake. The master holds a, b and op
// and the slave answers on result in the same cycle and on result_q one
// clock later. Every cycle carries data and no stall is possible.
interface mux5bit_2to1_if
  import mux5bit_2to1_pkg::*;
#(
  parameter int WIDTH = REG_ADDR_W
) ();

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_q;

  // Side that supplies operands and the select line.
  modport master (
    output a,
    output b,
    output op,
    input  result,
    input  result_q
  );

  // Side that performs the selection.
  modport slave (
    input  a,
    input  b,
    input  op,
    output result,
    output result_q
  );

endinterface : mux5bit_2to1_if

// File: rtl/mux5bit_2to1_mux2.sv
// Pure combinational WIDTH-bit 2-to-1 selector.
// A continuous ternary is used on purpose. If i_op is X or Z in simulation,
// bits where i_a and i_b agree pass through, and bits where they differ
// become X. It holds no state, so no latch can be inferred.
module mux5bit_2to1_mux2
  import mux5bit_2to1_pkg::*;
#(
  parameter int WIDTH = REG_ADDR_W
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_op,
  output logic [WIDTH-1:0] o_result
);

  // i_op = 1 selects i_b; anything else that resolves to 0 selects i_a.
  assign o_result = i_op ? i_b : i_a;

endmodule : mux5bit_2to1_mux2

// File: rtl/mux5bit_2to1.sv
// Datapath register-address/operand select mux.
// result is the same-cycle combinational pick. result_q is the same pick
// registered once for pipelined consumers. The port order a, b, op, result
// comes first so that legacy positional instantiations still bind correctly.
module mux5bit_2to1
  import mux5bit_2to1_pkg::*;
#(
  parameter int WIDTH = REG_ADDR_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic [WIDTH-1:0] result,
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] result_q
);

  // Reject widths outside the supported 1..32 range at elaboration time.
  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("mux5bit_2to1: WIDTH must be in 1..32");
    end
  endgenerate

  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] r_result_q;

  mux5bit_2to1_mux2 #(
    .WIDTH (WIDTH)
  ) u_mux2 (
    .i_a      (a),
    .i_b      (b),
    .i_op     (op),
    .o_result (w_result)
  );

  // Register the selection. Synchronous reset has priority over the data path.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result_q <= '0;
    end else begin
      r_result_q <= w_result;
    end
  end

  assign result   = w_result;
  assign result_q = r_result_q;

endmodule : mux5bit_2to1

// File: tb/tb_mux5bit_2to1.sv
// Bench for mux5bit_2to1 at the default width (5) and at WIDTH = 8.
module tb_mux5bit_2to1;

  logic clk;
  logic reset;

  mux5bit_2to1_if #(.WIDTH(5)) bus5 ();
  mux5bit_2to1_if #(.WIDTH(8)) bus8 ();

  mux5bit_2to1 dut5 (
    .a        (bus5.a),
    .b        (bus5.b),
    .op       (bus5.op),
    .result   (bus5.result),
    .clk      (clk),
    .reset    (reset),
    .result_q (bus5.result_q)
  );

  mux5bit_2to1 #(.WIDTH(8)) dut8 (
    .a        (bus8.a),
    .b        (bus8.b),
    .op       (bus8.op),
    .result   (bus8.result),
    .clk      (clk),
    .reset    (reset),
    .result_q (bus8.result_q)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [4:0] exp5_q[$];    // expected result, 5-bit
  logic [7:0] exp8_q[$];    // expected result, 8-bit
  logic [4:0] exp5r_q[$];   // expected result_q after next edge, 5-bit
  logic [7:0] exp8r_q[$];   // expected result_q after next edge, 8-bit
  int n_tests = 0;
  int n_fail  = 0;
  event ev_comb;

  // Reference model: op is treated as a 0/1 weight on the two operands.
  function automatic longint pick(input longint av, input longint bv, input bit s);
    longint w;
    w = longint'(s);
    return av * (1 - w) + bv * w;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Apply one cycle of stimulus at the falling edge and push expectations.
  task automatic drive(input logic [4:0] a5, input logic [4:0] b5,
                       input logic [7:0] a8, input logic [7:0] b8,
                       input bit s, input bit rst);
    @(negedge clk);
    bus5.a = a5;
    bus5.b = b5;
    bus5.op = s;
    bus8.a = a8;
    bus8.b = b8;
    bus8.op = s;
    reset = rst;
    exp5_q.push_back(5'(pick(longint'(a5), longint'(b5), s)));
    exp8_q.push_back(8'(pick(longint'(a8), longint'(b8), s)));
    exp5r_q.push_back(rst ? 5'd0 : 5'(pick(longint'(a5), longint'(b5), s)));
    exp8r_q.push_back(rst ? 8'd0 : 8'(pick(longint'(a8), longint'(b8), s)));
    -> ev_comb;
  endtask

  // ---------------- monitors ----------------
  // Combinational output: check 1 time unit after each stimulus change.
  initial begin
    forever begin
      @(ev_comb);
      #1;
      if (exp5_q.size() > 0) check("result5", longint'(bus5.result), longint'(exp5_q.pop_front()));
      if (exp8_q.size() > 0) check("result8", longint'(bus8.result), longint'(exp8_q.pop_front()));
    end
  end

  // Registered output: check 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp5r_q.size() > 0) check("result_q5", longint'(bus5.result_q), longint'(exp5r_q.pop_front()));
      if (exp8r_q.size() > 0) check("result_q8", longint'(bus8.result_q), longint'(exp8r_q.pop_front()));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset   = 1'b1;
    bus5.a  = '0;
    bus5.b  = '0;
    bus5.op = 1'b0;
    bus8.a  = '0;
    bus8.b  = '0;
    bus8.op = 1'b0;

    // Initial reset: result_q cleared while result follows inputs.
    drive(5'd1, 5'd2, 8'h11, 8'h22, 1'b0, 1'b1);
    drive(5'd1, 5'd2, 8'h11, 8'h22, 1'b1, 1'b1);

    // Basic selection, including the full-pattern 8-bit operands.
    drive(5'd2, 5'd3, 8'hA5, 8'h5A, 1'b0, 1'b0);
    drive(5'd2, 5'd3, 8'hA5, 8'h5A, 1'b1, 1'b0);

    // Toggle op with all-ones against all-zeros.
    drive(5'd31, 5'd0, 8'hFF, 8'h00, 1'b0, 1'b0);
    drive(5'd31, 5'd0, 8'hFF, 8'h00, 1'b1, 1'b0);
    drive(5'd31, 5'd0, 8'hFF, 8'h00, 1'b0, 1'b0);

    // Reset held for two edges with op = 1, then release and change op mid-cycle.
    drive(5'd7, 5'd9, 8'h07, 8'h09, 1'b1, 1'b1);
    drive(5'd7, 5'd9, 8'h07, 8'h09, 1'b1, 1'b1);
    drive(5'd7, 5'd9, 8'h07, 8'h09, 1'b1, 1'b0);
    drive(5'd7, 5'd9, 8'h07, 8'h09, 1'b0, 1'b0);

    // Reset held while op toggles every cycle.
    for (int i = 0; i < 6; i++) begin
      drive(5'd7, 5'd9, 8'hA5, 8'h5A, bit'(i % 2), 1'b1);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 60; i++) begin
      drive(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            bit'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    // Let the last expectations drain, then confirm nothing was left unchecked.
    repeat (3) @(posedge clk);
    #2;
    check("leftover_q", longint'(exp5_q.size() + exp8_q.size() + exp5r_q.size() + exp8r_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mux5bit_2to1
